// File: rtl/bus_transfer_sequencer.sv
// bus_transfer_sequencer: initiator-side sequencer for the shared 6-port tri-state bus.
// Requests (src,dst) are queued and each is played out as SETUP -> XFER -> RELEASE.
// Each port gets a 2-bit ctrl code: 10 means drive the bus, 01 means read it, 00 means idle.
// The RELEASE cycle always leaves every port idle, which gives the bus a turnaround gap.
// Optional feature: define BUS_XFER_STATS_EN to add the xfer_count and err_count outputs.
module bus_transfer_sequencer #(
   parameter int N_PORTS     = 6,
   parameter int QUEUE_DEPTH = 4,
   parameter int HOLD_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [2:0] req_src,
   input  logic [2:0] req_dst,
   output logic [1:0] ctrl_0,
   output logic [1:0] ctrl_1,
   output logic [1:0] ctrl_2,
   output logic [1:0] ctrl_3,
   output logic [1:0] ctrl_4,
   output logic [1:0] ctrl_5,
   output logic       busy,
   output logic       xfer_done,
   output logic       err_illegal
`ifdef BUS_XFER_STATS_EN
   ,
   output logic [15:0] xfer_count,
   output logic [7:0]  err_count
`endif
);

   localparam int AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(QUEUE_DEPTH);
   localparam logic [3:0] HOLD_M1 = 4'(HOLD_CYCLES - 1);

   typedef struct packed {
      logic [2:0] src;
      logic [2:0] dst;
   } req_t;

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_RELEASE} state_e;

   // ---------------- request FIFO ----------------
   req_t          mem_q [QUEUE_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          push, pop, q_empty, q_full;
   req_t          head;

   assign q_empty   = (cnt_q == '0);
   assign q_full    = (cnt_q == DEPTH_CNT);
   assign req_ready = ~q_full;
   assign push      = req_valid & ~q_full;
   assign head      = mem_q[rd_ptr_q];

   // Queue storage; entries need no reset because the count gates every read.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= '{src: req_src, dst: req_dst};
   end

   // Queue pointers and occupancy; pointers wrap naturally because the depth is a power of 2.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // ---------------- sequencer FSM ----------------
   state_e          state_q, state_d;
   logic [2:0]      src_q, src_d, dst_q, dst_d;
   logic [3:0]      hold_q, hold_d;
   logic [5:0][1:0] ctrl_q, ctrl_d;
   logic            done_q, done_d, err_q, err_d;
   logic            head_legal;

   assign head_legal = (head.src != head.dst) &&
                       (int'(head.src) < N_PORTS) && (int'(head.dst) < N_PORTS);

   // Next state plus next registered outputs; IDLE and RELEASE share the pop/dispatch path.
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      hold_d  = hold_q;
      ctrl_d  = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      pop     = 1'b0;
      case (state_q)
         S_IDLE, S_RELEASE: begin
            state_d = S_IDLE;
            if (!q_empty) begin
               pop = 1'b1;
               if (head_legal) begin
                  state_d            = S_SETUP;
                  src_d              = head.src;
                  dst_d              = head.dst;
                  ctrl_d[head.src]   = 2'b10;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_SETUP: begin
            state_d       = S_XFER;
            hold_d        = HOLD_M1;
            ctrl_d[src_q] = 2'b10;
            ctrl_d[dst_q] = 2'b01;
         end
         S_XFER: begin
            if (hold_q == '0) begin
               state_d = S_RELEASE;
               done_d  = 1'b1;
            end else begin
               hold_d        = hold_q - 1'b1;
               ctrl_d[src_q] = 2'b10;
               ctrl_d[dst_q] = 2'b01;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef BUS_XFER_STATS_EN
   logic [15:0] xfer_count_q, xfer_count_d;
   logic [7:0]  err_count_q, err_count_d;

   // Statistics: the transfer count wraps, the error count saturates.
   always_comb begin
      xfer_count_d = xfer_count_q;
      err_count_d  = err_count_q;
      if (done_q) xfer_count_d = xfer_count_q + 16'd1;
      if (err_q && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
   end

   assign xfer_count = xfer_count_q;
   assign err_count  = err_count_q;
`endif

   // All state, queue pointers and registered outputs; reset drops everything in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         src_q    <= '0;
         dst_q    <= '0;
         hold_q   <= '0;
         ctrl_q   <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
`ifdef BUS_XFER_STATS_EN
         xfer_count_q <= '0;
         err_count_q  <= '0;
`endif
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         hold_q   <= hold_d;
         ctrl_q   <= ctrl_d;
         done_q   <= done_d;
         err_q    <= err_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
`ifdef BUS_XFER_STATS_EN
         xfer_count_q <= xfer_count_d;
         err_count_q  <= err_count_d;
`endif
      end
   end

   assign ctrl_0      = ctrl_q[0];
   assign ctrl_1      = ctrl_q[1];
   assign ctrl_2      = ctrl_q[2];
   assign ctrl_3      = ctrl_q[3];
   assign ctrl_4      = ctrl_q[4];
   assign ctrl_5      = ctrl_q[5];
   assign xfer_done   = done_q;
   assign err_illegal = err_q;
   assign busy        = (state_q != S_IDLE) || !q_empty;

endmodule
